// File: rtl/usb_token_rx_if.sv
// usb_token_rx_if
//   UTMI-style receive byte stream between the PHY/SIE receive path and the
//   token receiver.
//   rx_active : high for the duration of a received packet
//   rx_valid  : rx_data holds a new byte this cycle
//   rx_data   : received byte, LSB = first bit on the wire
//   rx_error  : PHY error (bit-stuff/EOP); aborts the current packet
//   modport master : the side producing the stream (PHY / testbench)
//   modport slave  : the side consuming the stream (usb_token_rx)
interface usb_token_rx_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  modport master (output rx_active, rx_valid, rx_data, rx_error);
  modport slave  (input  rx_active, rx_valid, rx_data, rx_error);
endinterface

// File: rtl/usb_token_rx.sv
// usb_token_rx
//   Device-side receiver/checker for USB token packets (OUT, IN, SETUP, SOF).
//   Validates the PID check nibble, the byte count and the CRC5, then presents
//   the decoded address/endpoint or frame number with a one-cycle strobe.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     rx                  : receive byte stream (usb_token_rx_if.slave)
//     io_dev_addr_i       : own device address (used when ADDR_FILTER_EN=1)
//     io_token_valid_o    : one-cycle pulse, good token decoded
//     io_pid_o            : token PID of the last good token
//     io_addr_o, io_ep_o  : address/endpoint of the last good IN/OUT/SETUP
//     io_frame_o          : frame number of the last good SOF
//     io_crc_err_o        : one-cycle pulse, CRC5 mismatch
//     io_pid_err_o        : one-cycle pulse, PID check nibble mismatch
//     io_len_err_o        : one-cycle pulse, token with byte count other than 2
//     io_busy_o           : high in any state other than IDLE

// Serial USB CRC5 (x^5 + x^2 + 1) over 11 data bits, LSB first.
module UsbCrc5 (
  input  logic [4:0]  io_crc_i,
  input  logic [10:0] io_data_i,
  output logic [4:0]  io_crc_o
);
  logic [4:0] c;

  always_comb begin
    c = io_crc_i;
    for (int i = 0; i < 11; i++) begin
      c = {c[3:0], 1'b0} ^ (((io_data_i[i] ^ c[4]) == 1'b1) ? 5'h05 : 5'h00);
    end
  end

  assign io_crc_o = c;
endmodule

module usb_token_rx #(
  parameter bit ADDR_FILTER_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  usb_token_rx_if.slave        rx,
  input  logic [6:0]           io_dev_addr_i,
  output logic                 io_token_valid_o,
  output logic [3:0]           io_pid_o,
  output logic [6:0]           io_addr_o,
  output logic [3:0]           io_ep_o,
  output logic [10:0]          io_frame_o,
  output logic                 io_crc_err_o,
  output logic                 io_pid_err_o,
  output logic                 io_len_err_o,
  output logic                 io_busy_o
);
  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_PID       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [3:0] PID_SOF     = 4'h5;

  function automatic logic is_token_pid(input logic [3:0] p);
    case (p)
      4'h1, 4'h9, 4'h5, 4'hD: is_token_pid = 1'b1;
      default:                is_token_pid = 1'b0;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  byte1_q, byte1_d, byte2_q, byte2_d;
  logic [3:0]  tpid_q, tpid_d;
  logic        pid_err_d;
  logic        busy_q;
  logic        valid_q, crc_err_q, pid_err_q, len_err_q;
  logic [3:0]  pid_q;
  logic [6:0]  addr_q;
  logic [3:0]  ep_q;
  logic [10:0] frame_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte1_d   = byte1_q;
    byte2_d   = byte2_q;
    tpid_d    = tpid_q;
    pid_err_d = 1'b0;
    case (state_q)
      S_WAIT_IDLE: if (!rx.rx_active) state_d = S_IDLE;
      S_IDLE:      if (rx.rx_active) state_d = S_PID;
      S_PID: begin
        if (rx.rx_error) begin
          state_d = rx.rx_active ? S_DRAIN : S_IDLE;
        end else if (rx.rx_valid) begin
          if (rx.rx_data[7:4] != ~rx.rx_data[3:0]) begin
            pid_err_d = 1'b1;
            state_d   = S_DRAIN;
          end else if (is_token_pid(rx.rx_data[3:0])) begin
            tpid_d  = rx.rx_data[3:0];
            cnt_d   = 2'd0;
            // A token PID ending the packet on its own goes straight to
            // CHECK so the short packet still reports a length error.
            state_d = rx.rx_active ? S_DATA : S_CHECK;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (!rx.rx_active) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx.rx_error) begin
          state_d = rx.rx_active ? S_DRAIN : S_IDLE;
        end else begin
          // A byte arriving together with the falling active is counted
          // before the packet is evaluated.
          if (rx.rx_valid) begin
            if (cnt_q == 2'd0) byte1_d = rx.rx_data;
            if (cnt_q == 2'd1) byte2_d = rx.rx_data;
            if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
          end
          if (!rx.rx_active) state_d = S_CHECK;
        end
      end
      S_CHECK:     state_d = S_IDLE;
      S_DRAIN:     if (!rx.rx_active) state_d = S_IDLE;
      default:     state_d = S_WAIT_IDLE;
    endcase
  end

  // The packet is judged on the cycle that enters CHECK, so the registered
  // pulse is visible during the CHECK cycle itself.
  logic [4:0]  crc_raw, crc_wire;
  logic        go_check, len_ok, crc_ok, addr_miss, tok_ok, is_sof;

  UsbCrc5 u_crc5 (
    .io_crc_i  (5'h1F),
    .io_data_i ({byte2_d[2:0], byte1_d}),
    .io_crc_o  (crc_raw)
  );

  // Transmitted CRC is the complemented register, MSB first on the wire.
  assign crc_wire  = ~{crc_raw[0], crc_raw[1], crc_raw[2], crc_raw[3], crc_raw[4]};
  assign go_check  = (state_d == S_CHECK) && (state_q != S_CHECK);
  assign len_ok    = (cnt_d == 2'd2);
  assign crc_ok    = (byte2_d[7:3] == crc_wire);
  assign is_sof    = (tpid_d == PID_SOF);
  assign addr_miss = ADDR_FILTER_EN && !is_sof && (byte1_d[6:0] != io_dev_addr_i);
  assign tok_ok    = go_check && len_ok && crc_ok && !addr_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT_IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      pid_err_q <= 1'b0;
      len_err_q <= 1'b0;
      pid_q     <= 4'h0;
      addr_q    <= 7'h00;
      ep_q      <= 4'h0;
      frame_q   <= 11'h000;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      valid_q   <= tok_ok;
      crc_err_q <= go_check && len_ok && !crc_ok;
      pid_err_q <= pid_err_d;
      len_err_q <= go_check && !len_ok;
      if (tok_ok) begin
        pid_q <= tpid_d;
        if (is_sof) begin
          frame_q <= {byte2_d[2:0], byte1_d};
        end else begin
          addr_q <= byte1_d[6:0];
          ep_q   <= {byte2_d[2:0], byte1_d[7]};
        end
      end
    end
  end

  // Packet capture registers carry no reset; PID reloads the counter.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    byte1_q <= byte1_d;
    byte2_q <= byte2_d;
    tpid_q  <= tpid_d;
  end

  assign io_token_valid_o = valid_q;
  assign io_crc_err_o     = crc_err_q;
  assign io_pid_err_o     = pid_err_q;
  assign io_len_err_o     = len_err_q;
  assign io_busy_o        = busy_q;
  assign io_pid_o         = pid_q;
  assign io_addr_o        = addr_q;
  assign io_ep_o          = ep_q;
  assign io_frame_o       = frame_q;
endmodule

// File: tb/tb_usb_token_rx.sv
// tb_usb_token_rx
//   Drives one receive stream into two receivers (address filter off / on)
//   and compares pulses, pulse timing and held fields against a packet-level
//   reference model with an independent polynomial-division CRC5.
module tb_usb_token_rx;
  localparam int C_NONE = 0;
  localparam int C_GOOD = 1;
  localparam int C_CRC  = 2;
  localparam int C_PID  = 3;
  localparam int C_LEN  = 4;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] dev_addr;
  always #5 clk = ~clk;

  usb_token_rx_if rxif ();

  logic        tv[2], ce[2], pe[2], le[2], bz[2];
  logic [3:0]  pid[2];
  logic [6:0]  addr[2];
  logic [3:0]  ep[2];
  logic [10:0] frame[2];

  usb_token_rx #(.ADDR_FILTER_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .rx(rxif), .io_dev_addr_i(dev_addr),
    .io_token_valid_o(tv[0]), .io_pid_o(pid[0]), .io_addr_o(addr[0]),
    .io_ep_o(ep[0]), .io_frame_o(frame[0]), .io_crc_err_o(ce[0]),
    .io_pid_err_o(pe[0]), .io_len_err_o(le[0]), .io_busy_o(bz[0])
  );

  usb_token_rx #(.ADDR_FILTER_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .rx(rxif), .io_dev_addr_i(dev_addr),
    .io_token_valid_o(tv[1]), .io_pid_o(pid[1]), .io_addr_o(addr[1]),
    .io_ep_o(ep[1]), .io_frame_o(frame[1]), .io_crc_err_o(ce[1]),
    .io_pid_err_o(pe[1]), .io_len_err_o(le[1]), .io_busy_o(bz[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_edge = 0;
  int cnt[2][4];
  int first_cyc[2];

  logic [7:0]  pkt_q[$];
  logic [3:0]  m_pid[2];
  logic [6:0]  m_addr[2];
  logic [3:0]  m_ep[2];
  logic [10:0] m_frame[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high samples of each pulse output per receiver.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ((tv[d] || ce[d] || pe[d] || le[d]) && first_cyc[d] < 0) first_cyc[d] = cyc;
      if (tv[d]) cnt[d][0]++;
      if (ce[d]) cnt[d][1]++;
      if (pe[d]) cnt[d][2]++;
      if (le[d]) cnt[d][3]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // CRC5 by polynomial long division: message bits (first on wire = highest
  // degree) times x^5, plus the all-ones preset term, reduced by x^5+x^2+1.
  // Returns byte2[7:3] as it should appear on the wire.
  function automatic logic [4:0] crc_field(input logic [10:0] f);
    logic [15:0] v;
    logic [4:0]  r, o;
    v = 16'hF800;
    for (int k = 0; k < 11; k++) v[15-k] = v[15-k] ^ f[k];
    for (int b = 15; b >= 5; b--) if (v[b]) v[b -: 6] = v[b -: 6] ^ 6'b100101;
    r = v[4:0];
    for (int j = 0; j < 5; j++) o[j] = ~r[4-j];
    return o;
  endfunction

  function automatic int model(input bit filt);
    logic [7:0]  p, b1, b2;
    logic [10:0] f;
    if (pkt_q.size() == 0) return C_NONE;
    p = pkt_q[0];
    if (p[7:4] != ~p[3:0]) return C_PID;
    if (!(p[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD})) return C_NONE;
    if (pkt_q.size() != 3) return C_LEN;
    b1 = pkt_q[1];
    b2 = pkt_q[2];
    f  = {b2[2:0], b1};
    if (b2[7:3] != crc_field(f)) return C_CRC;
    if (filt && p[3:0] != 4'h5 && b1[6:0] != dev_addr) return C_NONE;
    return C_GOOD;
  endfunction

  task automatic model_update(input int d);
    logic [7:0] p, b1, b2;
    p  = pkt_q[0];
    b1 = pkt_q[1];
    b2 = pkt_q[2];
    m_pid[d] = p[3:0];
    if (p[3:0] == 4'h5) m_frame[d] = {b2[2:0], b1};
    else begin
      m_addr[d] = b1[6:0];
      m_ep[d]   = {b2[2:0], b1[7]};
    end
  endtask

  function automatic logic [15:0] exp_vec(input int code);
    case (code)
      C_GOOD:  return 16'h1000;
      C_CRC:   return 16'h0100;
      C_PID:   return 16'h0010;
      C_LEN:   return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] obs_vec(input int d);
    return {cnt[d][0][3:0], cnt[d][1][3:0], cnt[d][2][3:0], cnt[d][3][3:0]};
  endfunction

  // ---------------- stimulus ----------------
  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) cnt[d][k] = 0;
      first_cyc[d] = -1;
    end
  endtask

  task automatic send_bytes(input bit fall_last);
    clr_counts();
    @(posedge clk); #1;
    rxif.rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < pkt_q.size(); i++) begin
      rxif.rx_data  = pkt_q[i];
      rxif.rx_valid = 1'b1;
      if (fall_last && i == pkt_q.size() - 1) begin
        rxif.rx_active = 1'b0;
        fall_edge = cyc + 1;
      end
      @(posedge clk); #1;
    end
    rxif.rx_valid = 1'b0;
  endtask

  task automatic end_pkt();
    if (rxif.rx_active) begin
      rxif.rx_active = 1'b0;
      fall_edge = cyc + 1;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({tv[d], ce[d], pe[d], le[d], bz[d], pid[d], addr[d], ep[d], frame[d]} !== 35'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got=%h want=0", d,
                 {tv[d], ce[d], pe[d], le[d], bz[d], pid[d], addr[d], ep[d], frame[d]});
      end
      m_pid[d] = 4'h0; m_addr[d] = 7'h0; m_ep[d] = 4'h0; m_frame[d] = 11'h0;
    end
    reset = 1'b0;
    idle(2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (bz[d] !== 1'b0) begin
        bad++;
        $display("FAIL idle_busy dut%0d got=%b want=0", d, bz[d]);
      end
    end
  endtask

  task automatic test_setup();
    int code;
    dev_addr = 7'h00;
    pkt_q = '{8'h2D, 8'h00, 8'h10};
    send_bytes(1'b0);
    end_pkt();
    for (int d = 0; d < 2; d++) begin
      code = model(d == 1);
      total++;
      if (code != C_GOOD || obs_vec(d) !== exp_vec(code)) begin
        bad++;
        $display("FAIL setup_pulses dut%0d got=%h want=%h", d, obs_vec(d), exp_vec(C_GOOD));
      end
      total++;
      if (first_cyc[d] != fall_edge) begin
        bad++;
        $display("FAIL setup_latency dut%0d got=%0d want=%0d", d, first_cyc[d], fall_edge);
      end
      model_update(d);
      total++;
      if ({pid[d], addr[d], ep[d]} !== {4'hD, 7'h00, 4'h0} ||
          {pid[d], addr[d], ep[d], frame[d]} !== {m_pid[d], m_addr[d], m_ep[d], m_frame[d]}) begin
        bad++;
        $display("FAIL setup_fields dut%0d got=%h want=%h", d, {pid[d], addr[d], ep[d]},
                 {4'hD, 7'h00, 4'h0});
      end
    end
  endtask

  task automatic test_crc_err();
    dev_addr = 7'h00;
    pkt_q = '{8'h2D, 8'h00, 8'h18};
    send_bytes(1'b0);
    end_pkt();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== exp_vec(model(d == 1))) begin
        bad++;
        $display("FAIL crc_pulses dut%0d got=%h want=%h", d, obs_vec(d), exp_vec(model(d == 1)));
      end
      total++;
      if (first_cyc[d] != fall_edge) begin
        bad++;
        $display("FAIL crc_latency dut%0d got=%0d want=%0d", d, first_cyc[d], fall_edge);
      end
      total++;
      if ({pid[d], addr[d], ep[d], frame[d]} !== {m_pid[d], m_addr[d], m_ep[d], m_frame[d]}) begin
        bad++;
        $display("FAIL crc_fields_held dut%0d got=%h want=%h", d,
                 {pid[d], addr[d], ep[d], frame[d]}, {m_pid[d], m_addr[d], m_ep[d], m_frame[d]});
      end
    end
  endtask

  task automatic test_pid_err();
    pkt_q = '{8'h2C, 8'h00, 8'h10};
    send_bytes(1'b0);
    idle(2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (bz[d] !== 1'b1) begin
        bad++;
        $display("FAIL pid_drain_busy dut%0d got=%b want=1", d, bz[d]);
      end
    end
    end_pkt();
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== exp_vec(model(d == 1)) || bz[d] !== 1'b0) begin
        bad++;
        $display("FAIL pid_pulses dut%0d got=%h busy=%b want=%h busy=0", d, obs_vec(d), bz[d],
                 exp_vec(model(d == 1)));
      end
    end
  endtask

  task automatic test_len_err();
    int code;
    logic [7:0] set_b[4][4];
    int         set_n[4];
    bit         set_f[4];
    dev_addr = 7'h00;
    set_b[0] = '{8'h69, 8'h00, 8'h00, 8'h00}; set_n[0] = 2; set_f[0] = 1'b0;
    set_b[1] = '{8'h69, 8'h00, 8'h10, 8'h00}; set_n[1] = 4; set_f[1] = 1'b0;
    set_b[2] = '{8'hD2, 8'h00, 8'h00, 8'h00}; set_n[2] = 1; set_f[2] = 1'b0;
    set_b[3] = '{8'h2D, 8'h00, 8'h10, 8'h00}; set_n[3] = 3; set_f[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      pkt_q.delete();
      for (int i = 0; i < set_n[t]; i++) pkt_q.push_back(set_b[t][i]);
      send_bytes(set_f[t]);
      end_pkt();
      for (int d = 0; d < 2; d++) begin
        code = model(d == 1);
        total++;
        if (obs_vec(d) !== exp_vec(code)) begin
          bad++;
          $display("FAIL len_case%0d_pulses dut%0d got=%h want=%h", t, d, obs_vec(d), exp_vec(code));
        end
        if (code == C_LEN || code == C_GOOD) begin
          total++;
          if (first_cyc[d] != fall_edge) begin
            bad++;
            $display("FAIL len_case%0d_latency dut%0d got=%0d want=%0d", t, d, first_cyc[d], fall_edge);
          end
        end
        if (code == C_GOOD) model_update(d);
      end
    end
  endtask

  task automatic test_abort();
    // PHY error after byte1 with active still high
    dev_addr = 7'h00;
    clr_counts();
    @(posedge clk); #1 rxif.rx_active = 1'b1;
    @(posedge clk); #1 rxif.rx_valid = 1'b1; rxif.rx_data = 8'h2D;
    @(posedge clk); #1 rxif.rx_data = 8'h55;
    @(posedge clk); #1 rxif.rx_valid = 1'b0; rxif.rx_error = 1'b1;
    @(posedge clk); #1 rxif.rx_error = 1'b0; rxif.rx_valid = 1'b1; rxif.rx_data = 8'h10;
    @(posedge clk); #1 rxif.rx_valid = 1'b0;
    end_pkt();
    idle(2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== 16'h0000 ||
          {pid[d], addr[d], ep[d], frame[d]} !== {m_pid[d], m_addr[d], m_ep[d], m_frame[d]}) begin
        bad++;
        $display("FAIL rx_error_abort dut%0d pulses=%h fields=%h want pulses=0 fields=%h", d,
                 obs_vec(d), {pid[d], addr[d], ep[d], frame[d]},
                 {m_pid[d], m_addr[d], m_ep[d], m_frame[d]});
      end
    end
    // reset in the middle of a packet, active held high across it
    clr_counts();
    @(posedge clk); #1 rxif.rx_active = 1'b1;
    @(posedge clk); #1 rxif.rx_valid = 1'b1; rxif.rx_data = 8'h2D;
    @(posedge clk); #1 rxif.rx_data = 8'h00;
    @(posedge clk); #1 rxif.rx_valid = 1'b0; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_pid[d] = 4'h0; m_addr[d] = 7'h0; m_ep[d] = 4'h0; m_frame[d] = 11'h0;
    end
    pkt_q = '{8'h10, 8'h2D, 8'h00, 8'h10};
    for (int i = 0; i < pkt_q.size(); i++) begin
      rxif.rx_valid = 1'b1; rxif.rx_data = pkt_q[i];
      @(posedge clk); #1;
    end
    rxif.rx_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (bz[d] !== 1'b1) begin
        bad++;
        $display("FAIL wait_idle_busy dut%0d got=%b want=1", d, bz[d]);
      end
    end
    end_pkt();
    idle(2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== 16'h0000 || {pid[d], addr[d], ep[d], frame[d]} !== 26'd0) begin
        bad++;
        $display("FAIL reset_mid_packet dut%0d pulses=%h fields=%h want 0", d, obs_vec(d),
                 {pid[d], addr[d], ep[d], frame[d]});
      end
    end
    pkt_q = '{8'h2D, 8'h00, 8'h10};
    send_bytes(1'b0);
    end_pkt();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== exp_vec(C_GOOD) || pid[d] !== 4'hD) begin
        bad++;
        $display("FAIL after_reset_decode dut%0d pulses=%h pid=%h want pulses=%h pid=d", d,
                 obs_vec(d), pid[d], exp_vec(C_GOOD));
      end
      model_update(d);
    end
  endtask

  // Random SOF/IN/OUT/SETUP tokens, half with one corrupted bit in the
  // field/CRC bytes, mostly sent back to back with the minimum 1-cycle gap.
  task automatic test_back_to_back();
    int          code, gap;
    logic [3:0]  pn, pep;
    logic [6:0]  pa;
    logic [10:0] f;
    logic [23:0] w;
    bit          fl;
    dev_addr = 7'h2A;
    for (int n = 0; n < 48; n++) begin
      case ($urandom_range(0, 3))
        0:       pn = 4'h5;
        1:       pn = 4'h9;
        2:       pn = 4'h1;
        default: pn = 4'hD;
      endcase
      if (pn == 4'h5) f = 11'($urandom);
      else begin
        pa  = ($urandom_range(0, 1) == 1) ? dev_addr : 7'($urandom);
        pep = 4'($urandom);
        f   = {pep, pa};
      end
      w = {crc_field(f), f[10:8], f[7:0], ~pn, pn};
      if ($urandom_range(0, 1) == 1) w[$urandom_range(8, 23)] ^= 1'b1;
      pkt_q = '{w[7:0], w[15:8], w[23:16]};
      fl  = ($urandom_range(0, 3) == 0);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_bytes(fl);
      end_pkt();
      for (int d = 0; d < 2; d++) begin
        code = model(d == 1);
        total++;
        if (obs_vec(d) !== exp_vec(code)) begin
          bad++;
          $display("FAIL rand%0d_pulses dut%0d got=%h want=%h", n, d, obs_vec(d), exp_vec(code));
        end
        if (code != C_NONE) begin
          total++;
          if (first_cyc[d] != fall_edge) begin
            bad++;
            $display("FAIL rand%0d_latency dut%0d got=%0d want=%0d", n, d, first_cyc[d], fall_edge);
          end
        end
        if (code == C_GOOD) model_update(d);
        total++;
        if ({pid[d], addr[d], ep[d], frame[d]} !== {m_pid[d], m_addr[d], m_ep[d], m_frame[d]}) begin
          bad++;
          $display("FAIL rand%0d_fields dut%0d got=%h want=%h", n, d,
                   {pid[d], addr[d], ep[d], frame[d]}, {m_pid[d], m_addr[d], m_ep[d], m_frame[d]});
        end
      end
      if (gap > 0) idle(gap);
    end
    clr_counts();
    idle(4);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== 16'h0000) begin
        bad++;
        $display("FAIL quiet_tail dut%0d got=%h want=0", d, obs_vec(d));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dev_addr = 7'h00;
    rxif.rx_active = 1'b0;
    rxif.rx_valid  = 1'b0;
    rxif.rx_data   = 8'h00;
    rxif.rx_error  = 1'b0;
    clr_counts();
    test_reset();
    test_setup();
    test_crc_err();
    test_pid_err();
    test_len_err();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
